// File: rtl/seg_pkg.sv
// Shared constants for the BCD 7-segment scanner: segment codes, converter
// FSM states, digit slot indices and the BCD-to-segment decoder.
package seg_pkg;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } conv_state_e;

  localparam logic [1:0] IDX_LO_U = 2'd0;
  localparam logic [1:0] IDX_LO_T = 2'd1;
  localparam logic [1:0] IDX_HI_U = 2'd2;
  localparam logic [1:0] IDX_HI_T = 2'd3;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_seg_scanner_if.sv
// Display-word in / multiplexed 7-segment out bundle for bcd_seg_scanner.
interface bcd_seg_scanner_if #(
  parameter int unsigned FIELD_W = 6
);
  logic [2*FIELD_W-1:0] data_show;
  logic [3:0]           digit_en;
  logic [6:0]           segment;
  logic [3:0]           digit_sel;
  logic                 busy;

  modport master (
    output data_show,
    output digit_en,
    input  segment,
    input  digit_sel,
    input  busy
  );

  modport slave (
    input  data_show,
    input  digit_en,
    output segment,
    output digit_sel,
    output busy
  );
endinterface

// File: rtl/bin2bcd_dd.sv
// One-field serial double-dabble datapath: load clears the scratch BCD and
// latches the binary value; each shift does the add-3 step then shifts in the MSB.
module bin2bcd_dd #(
  parameter int unsigned FIELD_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [FIELD_W-1:0] bin_i,
  output logic [7:0]         bcd_o
);

  logic [FIELD_W-1:0] bin_q;
  logic [7:0]         bcd_q;
  logic [7:0]         adj;

  always_comb begin
    adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else if (load_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
    end else if (shift_i) begin
      bcd_q <= {adj[6:0], bin_q[FIELD_W-1]};
      bin_q <= {bin_q[FIELD_W-2:0], 1'b0};
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/bcd_seg_scanner.sv
// Converts two binary fields to BCD and scans them onto four 7-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero-valued tens digits.
module bcd_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned FIELD_W  = 6,
  parameter int unsigned SCAN_DIV = 8
) (
  input logic               clock,
  input logic               reset,
  bcd_seg_scanner_if.slave  bus
);

  localparam int unsigned DataW  = 2 * FIELD_W;
  localparam int unsigned CntW   = $clog2(FIELD_W);
  localparam int unsigned PrescW = $clog2(SCAN_DIV);

  conv_state_e      state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DataW-1:0] captured_q;
  logic             pending_q;
  logic             capture, commit, dd_shift;
  logic [7:0]       lo_bcd, hi_bcd;
  logic [3:0][3:0]  disp_q;

  bin2bcd_dd #(.FIELD_W(FIELD_W)) u_lo (
    .clock   (clock),
    .reset   (reset),
    .load_i  (capture),
    .shift_i (dd_shift),
    .bin_i   (bus.data_show[FIELD_W-1:0]),
    .bcd_o   (lo_bcd)
  );

  bin2bcd_dd #(.FIELD_W(FIELD_W)) u_hi (
    .clock   (clock),
    .reset   (reset),
    .load_i  (capture),
    .shift_i (dd_shift),
    .bin_i   (bus.data_show[DataW-1:FIELD_W]),
    .bcd_o   (hi_bcd)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    commit   = 1'b0;
    dd_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q || (bus.data_show != captured_q)) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        dd_shift = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(FIELD_W - 1)) state_d = StCommit;
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      captured_q <= '0;
      pending_q  <= 1'b1;
      disp_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        captured_q <= bus.data_show;
        pending_q  <= 1'b0;
      end
      // Both fields land together so the scan never sees a half-updated value
      if (commit) begin
        disp_q[IDX_LO_U] <= lo_bcd[3:0];
        disp_q[IDX_LO_T] <= lo_bcd[7:4];
        disp_q[IDX_HI_U] <= hi_bcd[3:0];
        disp_q[IDX_HI_T] <= hi_bcd[7:4];
      end
    end
  end

  assign bus.busy = (state_q != StIdle);

  logic [PrescW-1:0] presc_q;
  logic [1:0]        idx_q;
  logic [6:0]        segment_q, segment_d;
  logic [3:0]        digit_sel_q, digit_sel_d;
  logic [3:0]        slot_digit;
  logic              slot_show;
  logic              wrap;

  assign wrap = (presc_q == PrescW'(SCAN_DIV - 1));

  always_comb begin
    slot_digit = disp_q[idx_q];
    slot_show  = bus.digit_en[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
    if (((idx_q == IDX_LO_T) || (idx_q == IDX_HI_T)) && (slot_digit == 4'd0)) begin
      slot_show = 1'b0;
    end
`endif
    segment_d   = slot_show ? seg_decode(slot_digit) : SEG_BLANK;
    digit_sel_d = slot_show ? (4'b0001 << idx_q) : 4'b0000;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q     <= '0;
      idx_q       <= IDX_LO_U;
      segment_q   <= SEG_BLANK;
      digit_sel_q <= 4'b0000;
    end else if (wrap) begin
      presc_q     <= '0;
      idx_q       <= idx_q + 2'd1;
      segment_q   <= segment_d;
      digit_sel_q <= digit_sel_d;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign bus.segment   = segment_q;
  assign bus.digit_sel = digit_sel_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Randomised bench for bcd_seg_scanner against a decimal-arithmetic display model.
module tb_bcd_seg_scanner;

  localparam int FIELD_W  = 6;
  localparam int SCAN_DIV = 8;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZT = 7'h00;
`else
  localparam logic [6:0] ZT = 7'h3F;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bcd_seg_scanner_if #(.FIELD_W(FIELD_W)) dut_if ();

  bcd_seg_scanner #(.FIELD_W(FIELD_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dut_if)
  );

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a conversion is a fixed latency, then the display holds decimal digits
  int          m_edges;
  int          m_left;
  bit          m_pend;
  logic [11:0] m_cap;
  int          m_disp [4];
  logic [6:0]  m_seg;
  logic [3:0]  m_sel;

  function automatic logic [10:0] scan_out(input int n, input int d [4], input logic [3:0] en);
    int slot;
    bit show;
    slot = (n / SCAN_DIV - 1) % 4;
    show = en[slot];
`ifdef LEADING_ZERO_BLANK_EN
    if ((slot % 2 == 1) && (d[slot] == 0)) show = 1'b0;
`endif
    if (show) return {4'(1 << slot), seg_tab[d[slot]]};
    return 11'd0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_edges <= 0;
      m_left  <= 0;
      m_pend  <= 1'b1;
      m_cap   <= '0;
      m_disp  <= '{default: 0};
      m_seg   <= '0;
      m_sel   <= '0;
    end else begin
      m_edges <= m_edges + 1;
      if ((m_edges + 1) % SCAN_DIV == 0) begin
        {m_sel, m_seg} <= scan_out(m_edges + 1, m_disp, dut_if.digit_en);
      end
      if (m_left == 0) begin
        if (m_pend || (dut_if.data_show != m_cap)) begin
          m_cap  <= dut_if.data_show;
          m_pend <= 1'b0;
          m_left <= FIELD_W + 1;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_disp[0] <= int'(m_cap[5:0]) % 10;
          m_disp[1] <= int'(m_cap[5:0]) / 10;
          m_disp[2] <= int'(m_cap[11:6]) % 10;
          m_disp[3] <= int'(m_cap[11:6]) / 10;
        end
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clock) begin
    if (chk_on) begin
      check("model_seg", 32'(dut_if.segment), 32'(m_seg));
      check("model_sel", 32'(dut_if.digit_sel), 32'(m_sel));
      check("model_busy", 32'(dut_if.busy), 32'(m_left != 0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_in(input int hi, input int lo, input logic [3:0] en);
    dut_if.data_show = {6'(hi), 6'(lo)};
    dut_if.digit_en  = en;
  endtask

  // Waits for the idx0 slot, then checks each of the four slots in turn
  task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_seg [4];
    int guard;
    exp_seg = '{e0, e1, e2, e3};
    guard = 0;
    tick(1);
    while (!((m_edges > 0) && (m_edges % SCAN_DIV == 0) && ((m_edges / SCAN_DIV - 1) % 4 == 0))
           && (guard < 6 * SCAN_DIV)) begin
      tick(1);
      guard++;
    end
    if (guard >= 6 * SCAN_DIV) begin
      check({tag, "_sync"}, 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_seg%0d", tag, i), 32'(dut_if.segment), 32'(exp_seg[i]));
        check($sformatf("%s_sel%0d", tag, i), 32'(dut_if.digit_sel),
              (exp_seg[i] != 7'h00) ? 32'(1 << i) : 32'd0);
        tick(SCAN_DIV);
      end
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_seg"}, 32'(dut_if.segment), 32'd0);
    check({tag, "_sel"}, 32'(dut_if.digit_sel), 32'd0);
    check({tag, "_busy"}, 32'(dut_if.busy), 32'd0);
    tick(2);
    reset = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 4'hF);
    tick(3);
    check("rst_seg", 32'(dut_if.segment), 32'd0);
    check("rst_sel", 32'(dut_if.digit_sel), 32'd0);
    check("rst_busy", 32'(dut_if.busy), 32'd0);
    chk_on = 1'b1;
    reset  = 1'b1;

    for (int i = 0; i < 7; i++) begin
      tick(1);
      check("init_busy_hi", 32'(dut_if.busy), 32'd1);
    end
    tick(1);
    check("init_busy_lo", 32'(dut_if.busy), 32'd0);
    check("init_sel0", 32'(dut_if.digit_sel), 32'h1);
    check("init_seg0", 32'(dut_if.segment), 32'h3F);
    scan_check("zeros", 7'h3F, ZT, 7'h3F, ZT);

    set_in(23, 59, 4'hF);
    tick(SCAN_DIV);
    scan_check("v23_59", 7'h6F, 7'h6D, 7'h4F, 7'h5B);

    set_in(12, 34, 4'b0011);
    tick(SCAN_DIV);
    scan_check("en0011", 7'h66, 7'h4F, 7'h00, 7'h00);

    set_in(0, 10, 4'hF);
    tick(3);
    set_in(0, 45, 4'hF);
    tick(3 * SCAN_DIV);
    check("restart_busy", 32'(dut_if.busy), 32'd0);
    scan_check("v45", 7'h6D, 7'h66, 7'h3F, ZT);

    set_in(63, 63, 4'hF);
    tick(3);
    check("mid_busy", 32'(dut_if.busy), 32'd1);
    async_reset_check("mid_rst");
    tick(2 * SCAN_DIV);
    scan_check("v63", 7'h4F, 7'h7D, 7'h4F, 7'h7D);

    set_in(5, 7, 4'hF);
    tick(SCAN_DIV);
    scan_check("v5_7", 7'h07, ZT, 7'h6D, ZT);

    for (int n = 0; n < 150; n++) begin
      set_in(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 4'($urandom));
      if ($urandom_range(0, 19) == 0) async_reset_check("rnd_rst");
      tick(int'($urandom_range(1, 24)));
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scanner.md
Name: bcd_seg_scanner

Overview:
- Downstream display stage of the clock top. Takes the packed 12-bit display word (two 6-bit binary fields: hi = hour/month, lo = minute/day) and a 4-bit digit-enable mask.
- Converts both fields to BCD with a serial double-dabble FSM.
- Time-multiplexes four 7-segment digits with per-digit blanking.
- Replaces direct binary-to-segment mapping, so displayed values read as decimal.

Parameters:
- FIELD_W, 6, width of each binary field; data_show width is 2*FIELD_W.
- SCAN_DIV, 8, clock cycles per digit slot; power of two, minimum 2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- data_show  in  12  {hi[11:6], lo[5:0]}, unsigned binary, each field 0..63
- digit_en  in  4  bit i enables digit i; 0 blanks it
- segment  out  7  active-high {g,f,e,d,c,b,a}, registered
- digit_sel  out  4  one-hot, active-high digit strobe, registered
- busy  out  1  high while a conversion is in progress

Behaviour:
- Reset: asynchronous on reset low.
  - segment = 0, digit_sel = 0, busy = 0, scan index = 0, prescaler = 0.
  - All four BCD display registers = 0. Pending flag = 1, which forces one conversion after reset release.
- Digit map:
  - idx0 = lo units, idx1 = lo tens, idx2 = hi units, idx3 = hi tens.
  - digit_en bit i gates idx i.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx advances 0→1→2→3→0.
  - segment and digit_sel are registered from idx in the same cycle idx updates, so outputs change 1 clock after the wrap.
  - First digit_sel after reset = 4'b0001 at clock SCAN_DIV.
  - If digit_en[idx] = 0: digit_sel = 0 and segment = 0 for that slot.
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: if pending, or data_show differs from the captured copy, at edge N:
    - capture data_show;
    - clear the BCD scratch registers (2 × 8 bits);
    - clear pending;
    - go to SHIFT with cnt = 0.
  - SHIFT, edges N+1..N+FIELD_W:
    - per field, add 3 to any BCD nibble ≥5;
    - then shift left one bit, pulling in the field MSB.
    - Both fields convert in parallel. Leave SHIFT when cnt = FIELD_W-1.
  - COMMIT, edge N+FIELD_W+1: copy the scratch BCD into the display registers atomically, then return to IDLE.
  - New value is visible on the scan from edge N+FIELD_W+2 (default 8 clocks after the capture edge).
  - busy = 1 in SHIFT and COMMIT, 0 in IDLE.
- data_show changes during a conversion are ignored until IDLE. The IDLE compare then restarts the conversion, so a displayed value never mixes two inputs.
- Values 60..63 are converted faithfully (e.g. 63 → 6,3). No saturation.
- Segment codes, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Any nibble >9 (unreachable) → 00.
- Reset asserted mid-conversion: conversion aborted, display registers cleared, pending re-set; converts again after release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: a tens digit (idx1 or idx3) whose BCD value is 0 is blanked (segment = 0, digit_sel = 0) even when enabled. Units digits are never suppressed.
- Undefined: zeros always display, e.g. "05".

Decomposition:
- Shared package seg_pkg:
  - 7-segment code constants for 0..9 and SEG_BLANK;
  - FSM state encoding (IDLE/SHIFT/COMMIT);
  - digit index constants IDX_LO_U, IDX_LO_T, IDX_HI_U, IDX_HI_T.
- One sub-module bin2bcd_dd: single-field serial double-dabble step/shift datapath, instantiated twice and sequenced by the parent FSM.

Test Plan:
- Reset release with data_show = {6'd0, 6'd0}, digit_en = 4'hF → busy high 7 cycles; digit_sel scans 0001,0010,0100,1000 every 8 clocks; segment = 3F on each slot.
- data_show = {6'd23, 6'd59}, digit_en = F → display registers settle 8 clocks after the change; idx0..3 segment = 6F, 6D, 4F, 5B.
- digit_en = 4'b0011 with {6'd12, 6'd34} → idx0/1 show 66, 4F; idx2/3 slots have digit_sel = 0 and segment = 00.
- Change data_show from 10 to 45 (lo) 3 cycles into a conversion → first conversion completes showing 10; immediate second conversion; final lo digits = 6D, 66; no mixed value ever displayed.
- Assert reset mid-SHIFT with {6'd63, 6'd63} → outputs 0 immediately (asynchronous); after release, display reaches 6,3,6,3 (7D, 4F).
- With LEADING_ZERO_BLANK_EN, {6'd5, 6'd7} → idx1 and idx3 blanked; idx0 = 07, idx2 = 6D. Without the macro, idx1 and idx3 = 3F.
